// File: rtl/median_pixel_feeder.sv
// rtl/median_pixel_feeder.sv - buffered pixel source and median result collector for median_filter
module median_pixel_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] new_pixel,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] median_in,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  full
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [TW-1:0]       TMO_LIMIT  = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESENT,
        S_WAIT,
        S_CAPTURE,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [TW-1:0]         tmo_inc;
    logic                  ready_q;
    logic                  ready_rise;
    logic [DATA_WIDTH-1:0] new_pixel_q, new_pixel_d;
    logic [DATA_WIDTH-1:0] result_data_q, result_data_d;
    logic                  result_valid_q, result_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   rd_next;

    // Loads are only taken while idle and not full; wraps modulo DEPTH.
    assign wr_en      = (state_q == S_IDLE) && load_en && (count_q != FULL_COUNT);
    assign ready_rise = ready & ~ready_q;
    assign tmo_inc    = tmo_q + TW'(1);
    // Read pointer extended by one bit so a full buffer (count == DEPTH) terminates.
    assign rd_next    = {1'b0, rd_ptr_q} + (ADDR_WIDTH + 1)'(1);

    // Next-state and output computation for the streaming FSM.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        tmo_d          = tmo_q;
        new_pixel_d    = new_pixel_q;
        result_data_d  = result_data_q;
        result_valid_d = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        timeout_err_d  = timeout_err_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            count_d  = count_q + (ADDR_WIDTH + 1)'(1);
        end
        case (state_q)
            S_IDLE: begin
                // count_d already includes a load issued together with start.
                if (start) begin
                    if (count_d != '0) begin
                        state_d       = S_PRESENT;
                        rd_ptr_d      = '0;
                        tmo_d         = '0;
                        timeout_err_d = 1'b0;
                        busy_d        = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_PRESENT: begin
                new_pixel_d = mem_q[rd_ptr_q];
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (ready_rise) begin
                    state_d = S_CAPTURE;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        // Abort: the buffer is treated as emptied so the next load starts at slot 0.
                        timeout_err_d = 1'b1;
                        busy_d        = 1'b0;
                        count_d       = '0;
                        wr_ptr_d      = '0;
                        state_d       = S_IDLE;
                    end
                end
            end
            S_CAPTURE: begin
                result_data_d  = median_in;
                result_valid_d = 1'b1;
                rd_ptr_d       = rd_next[ADDR_WIDTH-1:0];
                tmo_d          = '0;
                state_d        = (rd_next == count_q) ? S_FINISH : S_PRESENT;
            end
            S_FINISH: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                count_d  = '0;
                wr_ptr_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel storage; contents are don't-care once count is cleared, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= load_data;
        end
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            tmo_q          <= '0;
            ready_q        <= 1'b0;
            new_pixel_q    <= '0;
            result_data_q  <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            tmo_q          <= tmo_d;
            ready_q        <= ready;
            new_pixel_q    <= new_pixel_d;
            result_data_q  <= result_data_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign new_pixel    = new_pixel_q;
    assign result_data  = result_data_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_err  = timeout_err_q;
    assign full         = (count_q == FULL_COUNT);

endmodule

// File: tb/tb_median_pixel_feeder.sv
// tb/tb_median_pixel_feeder.sv - randomized self-checking bench for median_pixel_feeder
module tb_median_pixel_feeder;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic [DW-1:0] new_pixel;
    logic          ready;
    logic [DW-1:0] median_in;
    logic          result_valid;
    logic [DW-1:0] result_data;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic          full;

    median_pixel_feeder #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data), .start(start),
        .new_pixel(new_pixel), .ready(ready), .median_in(median_in),
        .result_valid(result_valid), .result_data(result_data), .busy(busy),
        .done(done), .timeout_err(timeout_err), .full(full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mdl_count = 0;
    int resp_mode = 0;
    int dly_min = 2;
    int dly_max = 6;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        logic [DW-1:0] s[$];
        s = '{a, b, c};
        s.sort();
        return s[1];
    endfunction

    // Result monitor: every strobe records the captured median and the pixel it belongs to.
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] np_q[$];
    int done_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (result_valid) begin
                got_q.push_back(result_data);
                np_q.push_back(new_pixel);
            end
            if (done) done_cnt++;
        end
    end

    // Filter model: mode 0 echoes the pixel, 1 is a 3-tap median, 2 holds ready high after the first edge.
    initial begin
        bit prev_busy;
        bit fire;
        logic [DW-1:0] win[$];
        prev_busy = 1'b0;
        win = '{8'h00, 8'h00, 8'h00};
        ready = 1'b0;
        median_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_mode != 2) ready = 1'b0;
            fire = result_valid || (busy && !prev_busy);
            if (busy && !prev_busy) win = '{8'h00, 8'h00, 8'h00};
            prev_busy = busy;
            if (fire && !ready) begin
                repeat ($urandom_range(dly_max, dly_min)) @(posedge clk);
                #1;
                win.push_back(new_pixel);
                void'(win.pop_front());
                median_in = (resp_mode == 1) ? med3(win[0], win[1], win[2]) : new_pixel;
                ready = 1'b1;
                if (resp_mode != 2) begin
                    @(posedge clk);
                    #1;
                    ready = 1'b0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic run_stream(input logic [DW-1:0] pix[$], input int mode, input bit with_start,
                              input string tag);
        logic [DW-1:0] acc[$];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] w[$];
        int base;
        int dbase;
        int n;
        resp_mode = mode;
        base  = got_q.size();
        dbase = done_cnt;
        n = pix.size() - ((with_start && pix.size() > 0) ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            load_en = 1'b1;
            load_data = pix[i];
            @(posedge clk);
            #1;
            load_en = 1'b0;
            if (mdl_count < DEPTH) begin
                acc.push_back(pix[i]);
                mdl_count++;
            end
            check($sformatf("%s full%0d", tag, i), full, mdl_count == DEPTH);
        end
        start = 1'b1;
        if (n < pix.size()) begin
            load_en = 1'b1;
            load_data = pix[n];
            if (mdl_count < DEPTH) begin
                acc.push_back(pix[n]);
                mdl_count++;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        load_en = 1'b0;
        if (acc.size() == 0) begin
            check({tag, " empty_done"}, done, 1);
            check({tag, " empty_busy"}, busy, 0);
        end else begin
            check({tag, " busy"}, busy, 1);
        end
        for (int c = 0; c < 4000 && done_cnt == dbase && !timeout_err; c++) @(posedge clk);
        repeat (12) @(posedge clk);
        #1;
        w = '{8'h00, 8'h00, 8'h00};
        foreach (acc[i]) begin
            w.push_back(acc[i]);
            void'(w.pop_front());
            exp_q.push_back((mode == 1) ? med3(w[0], w[1], w[2]) : acc[i]);
        end
        check({tag, " n_results"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            check($sformatf("%s pix%0d", tag, i), np_q[base + i], acc[i]);
            check($sformatf("%s res%0d", tag, i), got_q[base + i], exp_q[i]);
        end
        check({tag, " done_cnt"}, done_cnt - dbase, 1);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " tmo_err"}, timeout_err, 0);
        check({tag, " full_end"}, full, 0);
        mdl_count = 0;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            load_en = 1'b1;
            load_data = DW'($urandom);
            @(posedge clk);
            #1;
        end
        load_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] p[$];
        int c;
        int cyc;
        int base;
        int dbase;

        repeat (2) @(posedge clk);
        #1;
        check("rst new_pixel", new_pixel, 0);
        check("rst result_valid", result_valid, 0);
        check("rst result_data", result_data, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst timeout_err", timeout_err, 0);
        check("rst full", full, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        p = {};
        run_stream(p, 0, 0, "empty");
        check("empty new_pixel", new_pixel, 0);

        p = '{8'hFF, 8'h00, 8'h80};
        run_stream(p, 0, 0, "basic");

        p = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h81, 8'h7E, 8'h02};
        run_stream(p, 1, 0, "median9");

        p = {};
        for (int i = 0; i < DEPTH + 1; i++) p.push_back(DW'($urandom));
        run_stream(p, 0, 0, "overfill");

        for (int it = 0; it < 6; it++) begin
            p = {};
            for (int i = 0; i < $urandom_range(12, 1); i++) p.push_back(DW'($urandom));
            run_stream(p, $urandom_range(1, 0), $urandom_range(1, 0) == 1, $sformatf("rand%0d", it));
        end

        // Ready stuck high after the first edge: one capture, then abort.
        resp_mode = 2;
        base  = got_q.size();
        dbase = done_cnt;
        load_words(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        while (!result_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("tmo first_result", result_valid, 1);
        cyc = 0;
        while (!timeout_err && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo latency", cyc, 256);
        repeat (3) @(posedge clk);
        #1;
        check("tmo n_results", got_q.size() - base, 1);
        check("tmo no_done", done_cnt - dbase, 0);
        check("tmo busy", busy, 0);
        check("tmo err", timeout_err, 1);
        check("tmo full", full, 0);
        resp_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        dbase = done_cnt;
        load_words(1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("tmo clear_err", timeout_err, 0);
        check("tmo clear_busy", busy, 1);
        for (int k = 0; k < 200 && done_cnt == dbase; k++) @(posedge clk);
        check("tmo restream_done", done_cnt - dbase, 1);

        // Reset while waiting on the second pixel's ready edge.
        repeat (12) @(posedge clk);
        #1;
        dly_min = 6;
        dly_max = 6;
        load_words(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        while (!result_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst new_pixel", new_pixel, 0);
        check("midrst result_valid", result_valid, 0);
        check("midrst result_data", result_data, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst timeout_err", timeout_err, 0);
        check("midrst full", full, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        dly_min = 2;
        dly_max = 6;
        mdl_count = 0;
        p = '{DW'($urandom), DW'($urandom)};
        run_stream(p, 1, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/median_pixel_feeder.md
Name: median_pixel_feeder

Overview:
Stream source and result collector for the median filter's pixel interface. It buffers a block of pixels written by a host, presents them one at a time on new_pixel, and advances on each rising edge of the filter's ready. On each advance it captures median_in and emits one result beat. It sits between host/frame logic and median_filter and replaces hand-driven stimulus in system-level runs.

Parameters:
DATA_WIDTH, 8, pixel and median width in bits
DEPTH, 16, pixel buffer entries (power of two)
ADDR_WIDTH, 4, log2(DEPTH)
TIMEOUT, 255, max cycles to wait for a ready rising edge before aborting

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
load_en  input  1  write load_data into buffer at write pointer
load_data  input  DATA_WIDTH  pixel to buffer
start  input  1  single-cycle pulse; begin streaming all buffered pixels
new_pixel  output  DATA_WIDTH  pixel presented to the filter
ready  input  1  filter ready/level; a rising edge means current pixel consumed and median valid
median_in  input  DATA_WIDTH  filter median output
result_valid  output  1  one-cycle strobe with result_data
result_data  output  DATA_WIDTH  captured median
busy  output  1  streaming in progress
done  output  1  one-cycle pulse at normal end of stream
timeout_err  output  1  sticky; set on timeout, cleared by next accepted start or rst
full  output  1  buffer holds DEPTH pixels

Behaviour:
- Reset (async, rst=1): every output 0, including new_pixel and result_data. Write pointer, read pointer, count, timeout counter, and ready_q are 0. State is IDLE. Reset mid-stream aborts immediately; buffered contents are discarded (count=0).
- Buffer: load_en in IDLE with count<DEPTH writes the word and increments count. Writes in other states, or when full, are ignored with no error. full = (count==DEPTH).
- Edge detect: ready_q is registered every cycle. ready_rise = ready & ~ready_q. Level-high ready never counts twice.
- FSM states: IDLE, PRESENT, WAIT, CAPTURE, FINISH.
- IDLE: start with count>0 goes to PRESENT. It clears read pointer, timeout counter and timeout_err, and sets busy=1. start with count==0 pulses done the next cycle, busy stays 0, and the state stays IDLE. start outside IDLE is ignored.
- PRESENT (1 cycle): new_pixel <= buf[rd_ptr], then go to WAIT. new_pixel holds until the next PRESENT.
- WAIT: on ready_rise go to CAPTURE. Otherwise the timeout counter increments. When it reaches TIMEOUT, set timeout_err=1, busy=0, count=0, and go to IDLE. No done pulse on timeout.
- CAPTURE (1 cycle): result_data <= median_in, result_valid=1 for exactly this cycle, rd_ptr++, timeout counter cleared.
  - rd_ptr==count after increment: go to FINISH.
  - Otherwise: go to PRESENT.
- FINISH (1 cycle): done=1, busy=0, count=0 (buffer emptied), write pointer=0, then IDLE.
- Latency per pixel: 1 PRESENT cycle, plus wait for ready_rise, plus 1 CAPTURE cycle. Earliest result_valid is 2 cycles after ready_rise is sampled in WAIT. A ready_rise already in progress at PRESENT is not counted; the edge must occur while in WAIT.
- Simultaneous events: rst dominates everything. load_en together with start in IDLE: the write is accepted and the stream includes the new word (count used is post-write). Pointers are ADDR_WIDTH bits and wrap modulo DEPTH; count is ADDR_WIDTH+1 bits.
- result_data holds its last value between strobes.

Test Plan:
1. Load FF,00,80 then start. Filter model pulses ready 3 cycles after each new_pixel change with median_in=pixel. Expect new_pixel sequence FF,00,80, three result_valid strobes with result_data FF,00,80, one done pulse, then busy=0.
2. Load 9 pixels (FF,00,80,7F,01,FE,81,7E,02) while the real median_filter (WINDOW_SIZE=3) is attached. Expect 9 result_valid strobes matching the filter's median_out at each ready edge, and done after the 9th.
3. Hold ready high permanently after the first edge. Expect exactly one capture, then timeout_err=1 after TIMEOUT=255 cycles in WAIT, busy=0, no done.
4. start with empty buffer. Expect done pulse the next cycle, no result_valid, new_pixel unchanged at 0.
5. Write 17 words with DEPTH=16. Expect full=1 after the 16th and the 17th ignored. Stream yields 16 results in write order.
6. Assert rst for 1 cycle during WAIT of pixel 2. Expect all outputs 0 immediately. A subsequent load of 2 pixels plus start streams correctly from pointer 0.
